// File: rtl/gf2m_reduce_seq.sv
// gf2m_reduce_seq
// Bit-serial reduction of an unreduced (2M-1)-bit carry-less product modulo
// a fixed degree-M irreducible polynomial POLY. One high-order coefficient
// is cleared per clock, walking idx from 2M-2 down to M. The result is
// handed out as an M-bit field element with valid/ready on both sides.
//
// Optional build macro: GF2M_REDUCE_EARLY_EXIT_EN
//   When defined, the block skips to DONE as soon as every coefficient at
//   or above x^M is zero. That check happens on the accept edge, or after
//   the XOR of any BUSY step. Results are unchanged; only the latency gets
//   shorter. When undefined, every input takes exactly M-1 BUSY cycles.
module gf2m_reduce_seq #(
    parameter int         M    = 6,
    parameter logic [M:0] POLY = 7'h43
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*M-2:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_data,
    output logic             busy
);

    localparam int W     = 2 * M - 1;
    localparam int IDX_W = $clog2(W);

    // POLY widened to the work-register width so that it can be shifted
    // into place under the current leading coefficient.
    localparam logic [W-1:0] POLY_EXT = W'(POLY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [W-1:0]         r_q;
    logic [W-1:0]         r_d;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     shift_amt;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic [M-1:0]         out_data_q;
    logic                 step_done;
`ifdef GF2M_REDUCE_EARLY_EXIT_EN
    logic                 in_upper_zero;
`endif

    // Single reduction step: cancel coefficient idx by XORing the modulus
    // aligned to that degree. The step count below decides when to stop.
    always_comb begin
        shift_amt = idx_q - IDX_W'(M);
        r_d       = r_q;
        if (r_q[idx_q]) begin
            r_d = r_q ^ (POLY_EXT << shift_amt);
        end
`ifdef GF2M_REDUCE_EARLY_EXIT_EN
        step_done     = (idx_q == IDX_W'(M)) || (r_d[W-1:M] == '0);
        in_upper_zero = (in_data[W-1:M] == '0);
`else
        step_done     = (idx_q == IDX_W'(M));
`endif
    end

    // Control FSM with work register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_q        <= in_data;
                        idx_q      <= IDX_W'(W - 1);
                        in_ready_q <= 1'b0;
`ifdef GF2M_REDUCE_EARLY_EXIT_EN
                        if (in_upper_zero) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= in_data[M-1:0];
                        end else begin
                            state_q <= ST_BUSY;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= ST_BUSY;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                ST_BUSY: begin
                    r_q   <= r_d;
                    idx_q <= idx_q - 1'b1;
                    if (step_done) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= r_d[M-1:0];
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_gf2m_reduce_seq.sv
// Testbench for gf2m_reduce_seq (default parameters M=6, POLY=x^6+x+1).
// The reference model reduces a product as a sum of precomputed x^i mod P
// residues, independently of the serial algorithm in the design.
module tb_gf2m_reduce_seq;

    localparam int M = 6;
    localparam int W = 2 * M - 1;
    localparam logic [M:0] POLY = 7'h43;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [M-1:0]   out_data;
    logic           busy;

    int tests;
    int fails;

    logic [M-1:0] pow_tab [W];

    gf2m_reduce_seq #(.M(M), .POLY(POLY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] din;
        logic [M-1:0] dout;
        int           nbusy;
    } vec_t;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // x^i mod P, built by repeated multiplication by x.
    task automatic build_pow();
        logic [M:0] t;
        t = (M+1)'(1);
        for (int i = 0; i < W; i++) begin
            pow_tab[i] = t[M-1:0];
            t = t << 1;
            if (t[M]) t = t ^ POLY;
        end
    endtask

    function automatic logic [M-1:0] model(input logic [W-1:0] d);
        logic [M-1:0] acc;
        acc = '0;
        for (int i = 0; i < W; i++)
            if (d[i]) acc = acc ^ pow_tab[i];
        return acc;
    endfunction

    // One full transaction; counts cycles with busy high until out_valid.
    task automatic run_op(input logic [W-1:0] d, output logic [M-1:0] res,
                          output int nbusy, output bit timeout);
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        nbusy    = 0;
        timeout  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                timeout = 1'b0;
                break;
            end
            if (busy) nbusy++;
            @(posedge clk); #1;
        end
        res = out_data;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    vec_t         vecs [7];
    logic [M-1:0] res;
    logic [M-1:0] held;
    int           nb;
    bit           to;
    int           exp_nb;

    initial begin
        tests = 0;
        fails = 0;
        build_pow();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        vecs[0] = '{din: 11'h000, dout: 6'h00, nbusy: 5};
        vecs[1] = '{din: 11'h400, dout: 6'h30, nbusy: 5};
        vecs[2] = '{din: 11'h7FF, dout: 6'h1E, nbusy: 5};
        vecs[3] = '{din: 11'h02A, dout: 6'h2A, nbusy: 5};
        vecs[4] = '{din: 11'h001, dout: 6'h01, nbusy: 5};
        vecs[5] = '{din: 11'h040, dout: 6'h03, nbusy: 5};
        vecs[6] = '{din: 11'h03F, dout: 6'h3F, nbusy: 5};
`ifdef GF2M_REDUCE_EARLY_EXIT_EN
        vecs[0].nbusy = 0;
        vecs[1].nbusy = 1;
        vecs[3].nbusy = 0;
        vecs[4].nbusy = 0;
        vecs[6].nbusy = 0;
`endif

        // Reset values
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_data", int'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].din, res, nb, to);
            check($sformatf("tab%0d_timeout", i), int'(to), 0);
            check($sformatf("tab%0d_data din=%0h", i, vecs[i].din), int'(res), int'(vecs[i].dout));
            check($sformatf("tab%0d_busycyc", i), nb, vecs[i].nbusy);
            check($sformatf("tab%0d_idle", i), int'(in_ready), 1);
            $display("[TB] table din=0x%03h out=0x%02h busy_cycles=%0d", vecs[i].din, res, nb);
        end

        // Randomized against model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] d;
            d = W'($urandom);
            run_op(d, res, nb, to);
            check($sformatf("rnd%0d_timeout", i), int'(to), 0);
            check($sformatf("rnd%0d_data din=%0h", i, d), int'(res), int'(model(d)));
`ifndef GF2M_REDUCE_EARLY_EXIT_EN
            check($sformatf("rnd%0d_busycyc", i), nb, M - 1);
`endif
            $display("[TB] random din=0x%03h out=0x%02h busy_cycles=%0d", d, res, nb);
        end

        // Reset during BUSY: no result may ever appear
        @(negedge clk);
        in_data  = 11'h7FF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        check("midbusy_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midbusy_out_valid", int'(out_valid), 0);
        check("midbusy_in_ready", int'(in_ready), 1);
        check("midbusy_busy", int'(busy), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                if (out_valid || busy) seen++;
            end
            check("midbusy_no_result", seen, 0);
        end
        out_ready = 1'b0;
        $display("[TB] reset mid-busy discarded 0x7FF");

        // Output backpressure
        @(negedge clk);
        in_data  = 11'h7FF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        check("bp_timeout", int'(to), 0);
        held = out_data;
        check("bp_data", int'(held), int'(6'h1E));
        begin
            int bad;
            bad = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                in_valid = c[0];
                in_data  = W'($urandom);
                if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b0)
                    bad++;
            end
            check("bp_stable", bad, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_out_valid", int'(out_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_extra_accept", int'(busy | out_valid), 0);
        $display("[TB] backpressure held 0x%02h for 10 cycles", held);

        // Back-to-back stream with out_ready held high
        begin
            logic [W-1:0] q_in [$];
            logic [M-1:0] q_out [$];
            int           t_out [$];
            int           cyc;
            q_in = '{11'h001, 11'h040, 11'h7FF};
            cyc = 0;
            out_ready = 1'b1;
            for (int c = 0; c < 60 && q_out.size() < 3; c++) begin
                @(negedge clk);
                cyc++;
                if (out_valid) begin
                    q_out.push_back(out_data);
                    t_out.push_back(cyc);
                end
                if (in_ready && q_in.size() > 0) begin
                    in_data  = q_in.pop_front();
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check("b2b_count", q_out.size(), 3);
            if (q_out.size() == 3) begin
                check("b2b_r0", int'(q_out[0]), int'(6'h01));
                check("b2b_r1", int'(q_out[1]), int'(6'h03));
                check("b2b_r2", int'(q_out[2]), int'(6'h1E));
`ifndef GF2M_REDUCE_EARLY_EXIT_EN
                check("b2b_gap01", t_out[1] - t_out[0], M + 1);
                check("b2b_gap12", t_out[2] - t_out[1], M + 1);
`endif
                for (int k = 0; k < 3; k++)
                    $display("[TB] stream result %0d = 0x%02h at cycle %0d", k, q_out[k], t_out[k]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
